// File: rtl/id_issue_buffer.sv
// Decode-to-execute issue buffer: in-order DEPTH-entry queue with valid/ready on both sides
// and a load-use scoreboard that holds back dependents of recently issued loads.
module id_issue_buffer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned PAYLOAD_W = 96,
   parameter int unsigned LOAD_LAT  = 1
) (
   input  logic                         clk,
   input  logic                         Rst,
   input  logic                         dbg,
   input  logic                         mem_hold,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [REG_AW-1:0]            in_rd,
   input  logic [REG_AW-1:0]            in_rs1,
   input  logic [REG_AW-1:0]            in_rs2,
   input  logic                         in_use_rs1,
   input  logic                         in_use_rs2,
   input  logic                         in_regwrite,
   input  logic                         in_memread,
   input  logic [PAYLOAD_W-1:0]         in_payload,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [REG_AW-1:0]            out_rd,
   output logic [REG_AW-1:0]            out_rs1,
   output logic [REG_AW-1:0]            out_rs2,
   output logic                         out_regwrite,
   output logic                         out_memread,
   output logic [PAYLOAD_W-1:0]         out_payload,
   output logic                         hz,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [REG_AW-1:0]    rd;
      logic [REG_AW-1:0]    rs1;
      logic [REG_AW-1:0]    rs2;
      logic                 use_rs1;
      logic                 use_rs2;
      logic                 regwrite;
      logic                 memread;
      logic [PAYLOAD_W-1:0] payload;
   } entry_t;

   entry_t                             mem_q [DEPTH];
   logic [PTR_W-1:0]                   rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]                   count_q;
   logic [LOAD_LAT-1:0]                sb_valid_q;
   logic [LOAD_LAT-1:0][REG_AW-1:0]    sb_rd_q;

   entry_t                             head, in_entry;
   logic                               freeze, full, empty, enq, issue;
   logic                               rs1_hit, rs2_hit, sb_new;
   logic [LOAD_LAT:0]                  sb_valid_ext;
   logic [LOAD_LAT:0][REG_AW-1:0]      sb_rd_ext;

   always_comb begin
      freeze   = dbg | mem_hold;
      full     = (count_q == CNT_W'(DEPTH));
      empty    = (count_q == '0);
      head     = mem_q[rd_ptr_q];
      in_entry = '{rd: in_rd, rs1: in_rs1, rs2: in_rs2, use_rs1: in_use_rs1,
                   use_rs2: in_use_rs2, regwrite: in_regwrite, memread: in_memread,
                   payload: in_payload};

      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      for (int i = 0; i < LOAD_LAT; i++) begin
         if (sb_valid_q[i] && (sb_rd_q[i] == head.rs1)) rs1_hit = 1'b1;
         if (sb_valid_q[i] && (sb_rd_q[i] == head.rs2)) rs2_hit = 1'b1;
      end

      // x0 is hardwired, so it never creates a dependency
      hz = !Rst && !empty && !freeze &&
           ((head.use_rs1 && (head.rs1 != '0) && rs1_hit) ||
            (head.use_rs2 && (head.rs2 != '0) && rs2_hit));

      out_valid = !Rst && !empty && !freeze && !hz && !flush;
      in_ready  = !Rst && !freeze && !full;
      enq       = in_valid && in_ready && !flush;
      issue     = out_valid && out_ready;
      sb_new    = issue && head.memread && (head.rd != '0);

      sb_valid_ext = {sb_valid_q, sb_new};
      sb_rd_ext    = {sb_rd_q, head.rd};

      out_rd       = Rst ? '0 : head.rd;
      out_rs1      = Rst ? '0 : head.rs1;
      out_rs2      = Rst ? '0 : head.rs2;
      out_regwrite = Rst ? 1'b0 : head.regwrite;
      out_memread  = Rst ? 1'b0 : head.memread;
      out_payload  = Rst ? '0 : head.payload;
      count        = Rst ? '0 : count_q;
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         mem_q      <= '{default: '0};
         sb_valid_q <= '0;
         sb_rd_q    <= '0;
      end else if (!freeze) begin
         if (enq) begin
            mem_q[wr_ptr_q] <= in_entry;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (flush) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
         end else begin
            if (issue) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (enq && !issue)      count_q <= count_q + CNT_W'(1);
            else if (!enq && issue) count_q <= count_q - CNT_W'(1);
         end
         // Loads already issued are older than anything flushed, so the scoreboard keeps them
         sb_valid_q <= sb_valid_ext[LOAD_LAT-1:0];
         sb_rd_q    <= sb_rd_ext[LOAD_LAT-1:0];
      end
   end

endmodule
